// File: rtl/task_scheduler_param_if.sv
// Handshake and data bundle between the task scheduler and its environment.
// The scheduler connects through the slave modport; the driving side uses master.
interface task_scheduler_param_if #(
  parameter int NUM_CORES = 4,
  parameter int REG_W     = 8,
  parameter int TM_DEPTH  = 64,
  parameter int FRAME_W   = 64
);
  localparam int AW = $clog2(TM_DEPTH);

  logic                       tm_wr_en;
  logic [AW-1:0]              tm_wr_addr;
  logic [FRAME_W-1:0]         tm_wr_data;
  logic                       run;
  logic [NUM_CORES-1:0]       ready;
  logic [NUM_CORES-1:0]       start;
  logic [FRAME_W-1:0]         insn_data;
  logic [NUM_CORES-1:0]       init_r0_vec;
  logic [NUM_CORES*REG_W-1:0] init_r0;
  logic                       busy;
  logic                       done;
  logic                       error;

  modport master (
    output tm_wr_en, tm_wr_addr, tm_wr_data, run, ready,
    input  start, insn_data, init_r0_vec, init_r0, busy, done, error
  );

  modport slave (
    input  tm_wr_en, tm_wr_addr, tm_wr_data, run, ready,
    output start, insn_data, init_r0_vec, init_r0, busy, done, error
  );
endinterface

// File: rtl/task_scheduler_param.sv
// Task scheduler: walks control/instruction frames from a loadable task memory
// and issues one-cycle start pulses to N cores, gated by ready and fence modes.
module task_scheduler_param #(
  parameter int NUM_CORES = 4,
  parameter int REG_W     = 8,
  parameter int TM_DEPTH  = 64,
  parameter int FRAME_W   = 64,
  parameter int CNT_W     = 8
) (
  input logic                   clk,
  input logic                   reset,
  task_scheduler_param_if.slave bus
);
  localparam int N         = NUM_CORES;
  localparam int AW        = $clog2(TM_DEPTH);
  localparam int R0V_LSB   = N;
  localparam int FENCE_LSB = 2 * N;
  localparam int CNT_LSB   = 2 * N + 2;
  localparam int HALT_BIT  = CNT_LSB + CNT_W;
  localparam int R0_LSB    = HALT_BIT + 1;

  localparam logic [1:0]    FENCE_ACQ = 2'd1;
  localparam logic [1:0]    FENCE_REL = 2'd2;
  localparam logic [AW-1:0] PTR_LAST  = AW'(TM_DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CTRL  = 3'd1,
    S_GUARD = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [N-1:0]           mask_q, mask_d;
  logic                   rel_q, rel_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [N-1:0]           start_q, start_d;
  logic [N-1:0]           r0v_q, r0v_d;
  logic [FRAME_W-1:0]     insn_q, insn_d;
  logic [N*REG_W-1:0]     r0_q, r0_d;

  logic [FRAME_W-1:0]     mem_q [TM_DEPTH];

  logic [FRAME_W-1:0]     frame_s;
  logic [N-1:0]           f_mask_s;
  logic [N-1:0]           f_r0v_s;
  logic [1:0]             f_fence_s;
  logic [CNT_W-1:0]       f_cnt_s;
  logic                   f_halt_s;
  logic [N*REG_W-1:0]     f_r0_s;
  logic                   ctrl_go_s;
  logic                   issue_go_s;
  logic                   last_s;

  assign frame_s   = mem_q[ptr_q];
  assign f_mask_s  = frame_s[N-1:0];
  assign f_r0v_s   = frame_s[R0V_LSB +: N];
  assign f_fence_s = frame_s[FENCE_LSB +: 2];
  assign f_cnt_s   = frame_s[CNT_LSB +: CNT_W];
  assign f_halt_s  = frame_s[HALT_BIT];
  assign f_r0_s    = frame_s[R0_LSB +: N*REG_W];
  assign last_s    = (ptr_q == PTR_LAST);

  // An acquire fence, or a release left pending by the previous control frame,
  // needs every core ready; otherwise only the selected cores must be ready.
  assign ctrl_go_s  = ((f_fence_s == FENCE_ACQ) || rel_q) ? (bus.ready == {N{1'b1}})
                                                           : ((bus.ready & f_mask_s) == f_mask_s);
  assign issue_go_s = ((bus.ready & mask_q) == mask_q);

  // Task memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.tm_wr_en && !busy_q) begin
      mem_q[bus.tm_wr_addr] <= bus.tm_wr_data;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    mask_d  = mask_q;
    rel_d   = rel_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    start_d = '0;
    r0v_d   = '0;
    insn_d  = insn_q;
    r0_d    = r0_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ptr_d   = '0;
          state_d = S_CTRL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CTRL: begin
        if (f_halt_s) begin
          state_d = S_DONE;
        end else if (ctrl_go_s) begin
          start_d = f_mask_s;
          insn_d  = frame_s;
          r0v_d   = f_r0v_s;
          r0_d    = f_r0_s;
          mask_d  = f_mask_s;
          rel_d   = (f_fence_s == FENCE_REL);
          rem_d   = f_cnt_s;
          ptr_d   = ptr_q + PTR_ONE;
          // The frame at the last address is still issued, then we stop.
          if (last_s) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (f_cnt_s != '0) begin
            state_d = S_GUARD;
          end else begin
            state_d = S_CTRL;
          end
        end else begin
          state_d = S_CTRL;
        end
      end
      S_GUARD: begin
        if (rem_q != '0) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_CTRL;
        end
      end
      S_ISSUE: begin
        if (issue_go_s) begin
          start_d = mask_q;
          insn_d  = frame_s;
          ptr_d   = ptr_q + PTR_ONE;
          rem_d   = rem_q - CNT_ONE;
          if (last_s) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_GUARD;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      mask_q  <= '0;
      rel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= '0;
      r0v_q   <= '0;
      insn_q  <= '0;
      r0_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      mask_q  <= mask_d;
      rel_q   <= rel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      r0v_q   <= r0v_d;
      insn_q  <= insn_d;
      r0_q    <= r0_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.insn_data   = insn_q;
  assign bus.init_r0_vec = r0v_q;
  assign bus.init_r0     = r0_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = err_q;
endmodule

// File: tb/tb_task_scheduler_param.sv
// Bench for task_scheduler_param: directed scenarios plus random programs,
// checked against an expected issue list computed from the frame rules.
module tb_task_scheduler_param;
  localparam int N     = 4;
  localparam int RW    = 8;
  localparam int DEPTH = 8;
  localparam int FW    = 64;
  localparam int CW    = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int F_R0V = N;
  localparam int F_FEN = 2 * N;
  localparam int F_CNT = 2 * N + 2;
  localparam int F_HLT = F_CNT + CW;
  localparam int F_R0  = F_HLT + 1;

  typedef struct {
    logic [N-1:0]    start;
    logic [FW-1:0]   insn;
    logic [N-1:0]    r0v;
    logic [N*RW-1:0] r0;
    bit              ctrl;
    logic [N-1:0]    need;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  task_scheduler_param_if #(.NUM_CORES(N), .REG_W(RW), .TM_DEPTH(DEPTH), .FRAME_W(FW)) bus ();

  task_scheduler_param #(
    .NUM_CORES(N), .REG_W(RW), .TM_DEPTH(DEPTH), .FRAME_W(FW), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_ev = 0;
  int last_st [N];
  logic [N-1:0] rdy_edge = '0;
  logic [N-1:0] fixed_ready = '0;
  logic [N-1:0] rnd_ready = '0;
  bit rand_mode = 1'b0;
  bit m_rel = 1'b0;
  bit exp_err = 1'b0;
  logic [FW-1:0] mem_img [DEPTH];
  ev_t exp_q [$];

  assign bus.ready = rand_mode ? rnd_ready : fixed_ready;

  // Cycle count and the ready value the DUT saw at each edge.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_edge <= bus.ready;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkctrl(input logic [N-1:0] m, input logic [N-1:0] rv,
                                           input logic [1:0] fe, input logic [CW-1:0] c,
                                           input logic h, input logic [N*RW-1:0] r0);
    logic [FW-1:0] f;
    f = {$urandom, $urandom};
    f[N-1:0]        = m;
    f[F_R0V +: N]   = rv;
    f[F_FEN +: 2]   = fe;
    f[F_CNT +: CW]  = c;
    f[F_HLT]        = h;
    f[F_R0 +: N*RW] = r0;
    return f;
  endfunction

  // Expected issue list for one run from address 0, following the frame rules.
  task automatic build_exp();
    int p;
    int c;
    bit stop;
    logic [FW-1:0] f;
    logic [N-1:0] m;
    ev_t e;
    exp_q.delete();
    exp_err = 1'b0;
    p = 0;
    stop = 1'b0;
    while (!stop) begin
      if (p >= DEPTH) begin
        exp_err = 1'b1;
        stop = 1'b1;
      end else begin
        f = mem_img[p];
        if (f[F_HLT]) begin
          stop = 1'b1;
        end else begin
          m = f[N-1:0];
          e.start = m; e.insn = f; e.r0v = f[F_R0V +: N]; e.r0 = f[F_R0 +: N*RW]; e.ctrl = 1'b1;
          e.need = (f[F_FEN +: 2] == 2'd1 || m_rel) ? {N{1'b1}} : m;
          if (e.start != '0 || e.r0v != '0) exp_q.push_back(e);
          m_rel = (f[F_FEN +: 2] == 2'd2);
          c = int'(f[F_CNT +: CW]);
          p++;
          for (int k = 0; k < c && !stop; k++) begin
            if (p >= DEPTH) begin
              exp_err = 1'b1;
              stop = 1'b1;
            end else begin
              e.start = m; e.insn = mem_img[p]; e.r0v = '0; e.r0 = '0; e.ctrl = 1'b0; e.need = m;
              if (m != '0) exp_q.push_back(e);
              p++;
            end
          end
        end
      end
    end
  endtask

  // One cycle: sample outputs after the edge, score any issue, then re-randomise ready.
  task automatic tick();
    ev_t e;
    @(negedge clk);
    if (bus.start != '0 || bus.init_r0_vec != '0) begin
      n_ev++;
      if (exp_q.size() == 0) begin
        chk("extra_issue", 64'({bus.start, bus.init_r0_vec}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("start", 64'(bus.start), 64'(e.start));
        chk("insn", bus.insn_data, e.insn);
        chk("r0vec", 64'(bus.init_r0_vec), 64'(e.r0v));
        if (e.ctrl) chk("r0", 64'(bus.init_r0), 64'(e.r0));
        chk("gate", 64'(rdy_edge & e.need), 64'(e.need));
        if (!e.ctrl) begin
          for (int i = 0; i < N; i++)
            if (e.start[i]) chk("spacing", 64'(cyc - last_st[i] >= 2), 64'd1);
        end
      end
      for (int i = 0; i < N; i++) if (bus.start[i]) last_st[i] = cyc;
    end
    for (int i = 0; i < N; i++) rnd_ready[i] = ($urandom_range(3) != 0);
  endtask

  task automatic load();
    for (int a = 0; a < DEPTH; a++) begin
      bus.tm_wr_en = 1'b1; bus.tm_wr_addr = AW'(a); bus.tm_wr_data = mem_img[a];
      tick();
    end
    bus.tm_wr_en = 1'b0;
  endtask

  task automatic do_run();
    build_exp();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!bus.done && k < 400) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_err"}, 64'(bus.error), 64'(exp_err));
  endtask

  initial begin
    int n0;
    int k;
    for (int i = 0; i < N; i++) last_st[i] = -100;
    reset = 1'b1;
    bus.run = 1'b0; bus.tm_wr_en = 1'b0; bus.tm_wr_addr = '0; bus.tm_wr_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_start", 64'(bus.start), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.error), 64'd0);
    chk("rst_r0v", 64'(bus.init_r0_vec), 64'd0);
    chk("rst_r0", 64'(bus.init_r0), 64'd0);
    chk("rst_insn", bus.insn_data, 64'd0);

    // Basic program: control + two instructions + halt.
    fixed_ready = 4'b1111;
    mem_img[0] = mkctrl(4'b0011, 4'b0001, 2'd0, 8'd2, 1'b0, 32'h0000_005A);
    mem_img[1] = {$urandom, $urandom};
    mem_img[2] = {$urandom, $urandom};
    mem_img[3] = mkctrl(4'b0000, 4'b0000, 2'd0, 8'd0, 1'b1, 32'h0);
    for (int a = 4; a < DEPTH; a++) mem_img[a] = {$urandom, $urandom};
    load();
    n0 = n_ev;
    do_run();
    chk("run_busy", 64'(bus.busy), 64'd1);
    wait_done("basic");
    chk("basic_nev", 64'(n_ev - n0), 64'd3);

    // Ready stall on both control and instruction issue.
    mem_img[0] = mkctrl(4'b0011, 4'b0000, 2'd0, 8'd1, 1'b0, 32'h0);
    mem_img[2] = mkctrl(4'b0000, 4'b0000, 2'd0, 8'd0, 1'b1, 32'h0);
    load();
    fixed_ready = 4'b0010;
    n0 = n_ev;
    do_run();
    repeat (4) tick();
    chk("stall_ctrl", 64'(n_ev - n0), 64'd0);
    fixed_ready = 4'b0011;
    tick();
    chk("ctrl_go", 64'(bus.start), 64'd3);
    fixed_ready = 4'b0010;
    repeat (4) tick();
    chk("stall_insn", 64'(n_ev - n0), 64'd1);
    fixed_ready = 4'b0011;
    tick();
    chk("insn_go", 64'(bus.start), 64'd3);
    wait_done("stall");

    // Release fence holds the next control frame until all cores are ready.
    mem_img[0] = mkctrl(4'b0001, 4'b0000, 2'd2, 8'd0, 1'b0, 32'h0);
    mem_img[1] = mkctrl(4'b0100, 4'b0000, 2'd0, 8'd0, 1'b0, 32'h0);
    mem_img[2] = mkctrl(4'b0000, 4'b0000, 2'd0, 8'd0, 1'b1, 32'h0);
    load();
    fixed_ready = 4'b1011;
    n0 = n_ev;
    do_run();
    repeat (4) tick();
    chk("rel_hold", 64'(n_ev - n0), 64'd1);
    fixed_ready = 4'b1111;
    tick();
    chk("rel_go", 64'(bus.start), 64'd4);
    wait_done("rel");

    // Acquire fence.
    mem_img[0] = mkctrl(4'b1000, 4'b0000, 2'd1, 8'd0, 1'b0, 32'h0);
    mem_img[1] = mkctrl(4'b0000, 4'b0000, 2'd0, 8'd0, 1'b1, 32'h0);
    load();
    fixed_ready = 4'b0111;
    n0 = n_ev;
    do_run();
    repeat (4) tick();
    chk("acq_hold", 64'(n_ev - n0), 64'd0);
    fixed_ready = 4'b1111;
    tick();
    chk("acq_go", 64'(bus.start), 64'd8);
    wait_done("acq");

    // No halt anywhere: pointer overflow after the last frame.
    for (int a = 0; a < DEPTH; a++)
      mem_img[a] = mkctrl(N'(a + 1), 4'b0000, 2'd0, 8'd0, 1'b0, 32'h0);
    load();
    n0 = n_ev;
    do_run();
    wait_done("ovf");
    chk("ovf_nev", 64'(n_ev - n0), 64'(DEPTH));
    do_run();
    chk("clr_done", 64'(bus.done), 64'd0);
    chk("clr_err", 64'(bus.error), 64'd0);
    wait_done("ovf2");

    // Asynchronous reset while stalled in instruction issue, then restart.
    mem_img[0] = mkctrl(4'b1111, 4'b0101, 2'd0, 8'd3, 1'b0, 32'hA1B2_C3D4);
    mem_img[4] = mkctrl(4'b0000, 4'b0000, 2'd0, 8'd0, 1'b1, 32'h0);
    load();
    n0 = n_ev;
    do_run();
    k = 0;
    while (n_ev == n0 && k < 50) begin tick(); k++; end
    chk("pre_rst_ev", 64'(n_ev - n0), 64'd1);
    fixed_ready = 4'b0000;
    repeat (3) tick();
    #1 reset = 1'b1;
    #1;
    chk("arst_start", 64'(bus.start), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_r0", 64'(bus.init_r0), 64'd0);
    #1 reset = 1'b0;
    m_rel = 1'b0;
    fixed_ready = 4'b1111;
    // Rewrite address 0 in the same cycle as run; the new frame must be used.
    mem_img[0] = mkctrl(4'b0110, 4'b0010, 2'd0, 8'd3, 1'b0, 32'h1122_3344);
    build_exp();
    bus.run = 1'b1; bus.tm_wr_en = 1'b1; bus.tm_wr_addr = '0; bus.tm_wr_data = mem_img[0];
    tick();
    bus.run = 1'b0; bus.tm_wr_en = 1'b0;
    wait_done("restart");

    // Random programs under random ready.
    rand_mode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int a;
      int c;
      for (int i = 0; i < DEPTH; i++) mem_img[i] = {$urandom, $urandom};
      a = 0;
      while (a < DEPTH) begin
        if (a > 0 && $urandom_range(4) == 0) begin
          mem_img[a] = mkctrl(N'($urandom), N'($urandom), 2'($urandom), 8'd0, 1'b1, 32'($urandom));
          a = DEPTH;
        end else begin
          c = $urandom_range(2);
          mem_img[a] = mkctrl(N'($urandom), N'($urandom), 2'($urandom), CW'(c), 1'b0, 32'($urandom));
          a = a + 1 + c;
        end
      end
      load();
      do_run();
      wait_done("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
